// File: rtl/goertzel_pkg.sv
// Shared definitions for the single-bin Goertzel datapath and its frame
// sequencer: state encoding, default sizes and the filter coefficient.
package goertzel_pkg;

    // Default widths and frame size for the 205-point DTMF-style bin.
    localparam int unsigned GZ_DATA_W    = 61;
    localparam int unsigned GZ_FRAME_LEN = 205;

    // 2*cos(2*pi*18/205) in signed Q2.16, used by the multiplier stage.
    localparam logic signed [17:0] GZ_COEF = 18'sd111626;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        CAPTURE,
        HOLD
    } state_t;

endpackage

// File: rtl/goertzel_frame_ctrl_if.sv
// Handshake/bus bundle between the frame sequencer, the Goertzel core and
// the result consumer.
//   master : sequencer view (drives sample_ready, core_en/clr, result)
//   slave  : environment view (drives samples, core y1/y2, res_ready)
interface goertzel_frame_ctrl_if
    import goertzel_pkg::*;
#(
    parameter int unsigned DATA_W = GZ_DATA_W
) ();

    logic                     sample_valid;
    logic                     sample_ready;
    logic                     core_en;
    logic                     core_clr;
    logic signed [DATA_W-1:0] core_y1;
    logic signed [DATA_W-1:0] core_y2;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [DATA_W-1:0] res_y1;
    logic signed [DATA_W-1:0] res_y2;

    modport master (
        input  sample_valid, core_y1, core_y2, res_ready,
        output sample_ready, core_en, core_clr, res_valid, res_y1, res_y2
    );

    modport slave (
        output sample_valid, core_y1, core_y2, res_ready,
        input  sample_ready, core_en, core_clr, res_valid, res_y1, res_y2
    );

endinterface

// File: rtl/goertzel_frame_cnt.sv
// Up-counter with synchronous clear and enable plus a terminal-count flag.
// The terminal value is an input so one counter serves both the sample
// count and the pipeline drain wait.
//   clk, rst   : clock, async active-low reset
//   clr_i      : synchronous clear to 0 (wins over en_i)
//   en_i       : increment
//   term_i     : terminal value
//   tc_o       : count equals term_i
module goertzel_frame_cnt #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] term_i,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/goertzel_frame_ctrl.sv
// Frame sequencer for the Goertzel core: clears the core, gates FRAME_LEN
// samples in via valid/ready, waits for the pipeline to drain, then captures
// y1/y2 into a result register offered downstream via valid/ready.
//   clk, rst : clock, async active-low reset
//   start    : begin a frame (IDLE only)
//   abort    : synchronous return to IDLE
//   busy     : state != IDLE
//   overrun  : sticky, unread result overwritten (continuous build only)
//   bus      : sample / core / result handshakes (master modport)
// Build option: define GOERTZEL_CTRL_CONTINUOUS_EN for back-to-back frames
// (CAPTURE goes straight to CLEAR; overrun becomes live).
module goertzel_frame_ctrl
    import goertzel_pkg::*;
#(
    parameter int unsigned FRAME_LEN = GZ_FRAME_LEN,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DATA_W    = GZ_DATA_W,
    parameter int unsigned CORE_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   overrun,
    goertzel_frame_ctrl_if.master  bus
);

    // Counter is widened to at least 3 bits so it can also time a drain of
    // up to 6 cycles on small frames.
    localparam int unsigned   CW         = (CNT_W > 3) ? CNT_W : 3;
    localparam logic [CW-1:0] LAST_SMP   = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((CORE_LAT > 1) ? (CORE_LAT - 2) : 0);

    state_t state_q, state_d;

    logic          hs;
    logic          cap;
    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_tc;
    logic [CW-1:0] cnt_term;

    logic                     res_valid_q, res_valid_d;
    logic signed [DATA_W-1:0] res_y1_q, res_y1_d;
    logic signed [DATA_W-1:0] res_y2_q, res_y2_d;

    assign hs  = bus.sample_valid && (state_q == RUN);
    assign cap = (state_q == CAPTURE);

    goertzel_frame_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (cnt_term),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        cnt_term = LAST_SMP;
        case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                cnt_clr = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (hs) begin
                    if (cnt_tc) begin
                        cnt_clr = 1'b1;
                        state_d = (CORE_LAT > 1) ? DRAIN : CAPTURE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            DRAIN: begin
                cnt_term = DRAIN_LAST;
                if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    state_d = CAPTURE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            CAPTURE: begin
`ifdef GOERTZEL_CTRL_CONTINUOUS_EN
                state_d = CLEAR;
`else
                state_d = HOLD;
`endif
            end
            HOLD: begin
                if (res_valid_q && bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The result register only loads in CAPTURE and clears on its own
    // handshake, so the same logic serves both builds (in the default build
    // res_valid is only ever high in HOLD).
    always_comb begin
        res_valid_d = res_valid_q;
        res_y1_d    = res_y1_q;
        res_y2_d    = res_y2_q;
        if (abort) begin
            res_valid_d = 1'b0;
        end else if (cap) begin
            res_valid_d = 1'b1;
            res_y1_d    = bus.core_y1;
            res_y2_d    = bus.core_y2;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_q <= 1'b0;
            res_y1_q    <= '0;
            res_y2_q    <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_y1_q    <= res_y1_d;
            res_y2_q    <= res_y2_d;
        end
    end

`ifdef GOERTZEL_CTRL_CONTINUOUS_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (abort) begin
            overrun_d = 1'b0;
        end else if (cap && res_valid_q && !bus.res_ready) begin
            overrun_d = 1'b1;
        end else if (start && (state_q == IDLE)) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign busy             = (state_q != IDLE);
    assign bus.sample_ready = (state_q == RUN);
    assign bus.core_en      = hs;
    assign bus.core_clr     = (state_q == CLEAR);
    assign bus.res_valid    = res_valid_q;
    assign bus.res_y1       = res_y1_q;
    assign bus.res_y2       = res_y2_q;

endmodule

// File: tb/tb_goertzel_frame_ctrl.sv
// Scoreboard bench for goertzel_frame_ctrl with FRAME_LEN=4, CORE_LAT=1.
// A small core model accumulates y1 += sample, y2 <= old y1 on core_en and
// counts core_clr pulses as frame numbers; frame fr uses samples
// {5,-3,7,100} + 256*fr, so y1 = 109 + 1024*fr and y2 = 9 + 768*fr.
module tb_goertzel_frame_ctrl;

    localparam int unsigned DW = 61;

    typedef struct {
        logic [DW-1:0] y1;
        logic [DW-1:0] y2;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic overrun;

    int checks = 0;
    int failures = 0;
    res_t sbq[$];

    goertzel_frame_ctrl_if #(.DATA_W(DW)) bus ();

    goertzel_frame_ctrl #(
        .FRAME_LEN (4),
        .CNT_W     (2),
        .DATA_W    (DW),
        .CORE_LAT  (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .busy    (busy),
        .overrun (overrun),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Core model
    logic [DW-1:0] m_y1, m_y2;
    int m_k, m_fr;

    function automatic logic [DW-1:0] smp(input int k, input int fr);
        longint v;
        case (k)
            0: v = 5;
            1: v = -3;
            2: v = 7;
            3: v = 100;
            default: v = 5000;
        endcase
        v = v + 256 * fr;
        return DW'(v);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_y1 <= '0;
            m_y2 <= '0;
            m_k  <= 0;
            m_fr <= 0;
        end else if (bus.core_clr) begin
            m_y1 <= '0;
            m_y2 <= '0;
            m_k  <= 0;
            m_fr <= m_fr + 1;
        end else if (bus.core_en) begin
            m_y2 <= m_y1;
            m_y1 <= m_y1 + smp(m_k, m_fr);
            m_k  <= m_k + 1;
        end
    end

    assign bus.core_y1 = m_y1;
    assign bus.core_y2 = m_y2;

    function automatic res_t exp_res(input int fr);
        res_t r;
        r.y1 = DW'(109 + 1024 * fr);
        r.y2 = DW'(9 + 768 * fr);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every accepted result against the scoreboard.
    always @(negedge clk) begin
        if (rst && bus.res_valid && bus.res_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got result y1=%0h expected none", bus.res_y1);
            end else begin
                res_t e;
                e = sbq.pop_front();
                chk("sb_y1", 64'(bus.res_y1), 64'(e.y1));
                chk("sb_y2", 64'(bus.res_y2), 64'(e.y2));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Starts in cycle 0 (IDLE) with valid held and res_ready=1; returns in
    // cycle 8 with the controller back in IDLE.
    task automatic do_frame(input int fr);
        start = 1'b1;
        bus.sample_valid = 1'b1;
        bus.res_ready = 1'b1;
        sbq.push_back(exp_res(fr));
        chk("frm_busy0", 64'(busy), 64'(0));
        tick;
        start = 1'b0;
        chk("frm_clr", 64'(bus.core_clr), 64'(1));
        chk("frm_rdy_clr", 64'(bus.sample_ready), 64'(0));
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("frm_en", 64'(bus.core_en), 64'(1));
        end
        tick;
        chk("frm_en_off", 64'(bus.core_en), 64'(0));
        chk("frm_rv_cap", 64'(bus.res_valid), 64'(0));
        tick;
        chk("frm_rv", 64'(bus.res_valid), 64'(1));
        tick;
        chk("frm_busy_end", 64'(busy), 64'(0));
        chk("frm_rv_end", 64'(bus.res_valid), 64'(0));
        bus.sample_valid = 1'b0;
    endtask

    initial begin
        int nfr;
        int enc;
        int pat[9];
        res_t e;
        bus.sample_valid = 1'b0;
        bus.res_ready = 1'b0;
        nfr = 0;

        // Reset state
        tick;
        tick;
        chk("rst_outs", 64'({bus.sample_ready, bus.core_en, bus.core_clr, bus.res_valid, busy, overrun}), 64'(0));
        chk("rst_y1", 64'(bus.res_y1), 64'(0));
        chk("rst_y2", 64'(bus.res_y2), 64'(0));
        rst = 1'b1;
        tick;
        chk("rst_rel_busy", 64'(busy), 64'(0));

`ifdef GOERTZEL_CTRL_CONTINUOUS_EN
        // Overrun: res_ready low through two captures
        start = 1'b1;
        bus.sample_valid = 1'b1;
        bus.res_ready = 1'b0;
        tick;
        start = 1'b0;
        repeat (6) tick;
        e = exp_res(nfr + 1);
        chk("c1_rv", 64'(bus.res_valid), 64'(1));
        chk("c1_ovr0", 64'(overrun), 64'(0));
        chk("c1_y1a", 64'(bus.res_y1), 64'(e.y1));
        repeat (5) tick;
        chk("c1_ovr_pre", 64'(overrun), 64'(0));
        tick;
        e = exp_res(nfr + 2);
        chk("c1_ovr1", 64'(overrun), 64'(1));
        chk("c1_rv2", 64'(bus.res_valid), 64'(1));
        chk("c1_y1b", 64'(bus.res_y1), 64'(e.y1));
        chk("c1_y2b", 64'(bus.res_y2), 64'(e.y2));
        sbq.push_back(e);
        bus.res_ready = 1'b1;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("c1_abort_busy", 64'(busy), 64'(0));
        chk("c1_abort_rv", 64'(bus.res_valid), 64'(0));
        chk("c1_abort_ovr", 64'(overrun), 64'(0));
        bus.sample_valid = 1'b0;
        bus.res_ready = 1'b0;
        nfr = nfr + 3;
        tick;

        // Consumer ready on the second capture cycle: no overrun
        start = 1'b1;
        bus.sample_valid = 1'b1;
        tick;
        start = 1'b0;
        repeat (11) tick;
        sbq.push_back(exp_res(nfr + 1));
        sbq.push_back(exp_res(nfr + 2));
        bus.res_ready = 1'b1;
        tick;
        e = exp_res(nfr + 2);
        chk("c2_rv", 64'(bus.res_valid), 64'(1));
        chk("c2_ovr", 64'(overrun), 64'(0));
        chk("c2_y1b", 64'(bus.res_y1), 64'(e.y1));
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("c2_busy", 64'(busy), 64'(0));
        bus.sample_valid = 1'b0;
        bus.res_ready = 1'b0;
        nfr = nfr + 3;
        tick;
`else
        // Basic frame
        nfr++;
        do_frame(nfr);

        // Stalled input
        pat = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
        enc = 0;
        nfr++;
        start = 1'b1;
        bus.sample_valid = 1'b0;
        bus.res_ready = 1'b1;
        sbq.push_back(exp_res(nfr));
        tick;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick;
            bus.sample_valid = (pat[i] != 0);
            #1;
            if (bus.core_en) enc++;
            if (i == 7) chk("stl_rv_cap", 64'(bus.res_valid), 64'(0));
            if (i == 8) chk("stl_rv", 64'(bus.res_valid), 64'(1));
        end
        chk("stl_en_cnt", 64'(enc), 64'(4));
        tick;
        chk("stl_busy", 64'(busy), 64'(0));
        bus.sample_valid = 1'b0;

        // Back-pressure
        nfr++;
        e = exp_res(nfr);
        start = 1'b1;
        bus.sample_valid = 1'b1;
        bus.res_ready = 1'b0;
        sbq.push_back(e);
        tick;
        start = 1'b0;
        repeat (6) tick;
        chk("bp_rv", 64'(bus.res_valid), 64'(1));
        for (int j = 0; j < 10; j++) begin
            chk("bp_y1", 64'(bus.res_y1), 64'(e.y1));
            chk("bp_y2", 64'(bus.res_y2), 64'(e.y2));
            chk("bp_rdy", 64'(bus.sample_ready), 64'(0));
            start = (j == 3);
            tick;
        end
        start = 1'b0;
        chk("bp_busy_hold", 64'(busy), 64'(1));
        bus.res_ready = 1'b1;
        tick;
        chk("bp_idle", 64'(busy), 64'(0));
        chk("bp_rv_clr", 64'(bus.res_valid), 64'(0));
        tick;
        chk("bp_idle2", 64'(busy), 64'(0));
        bus.sample_valid = 1'b0;

        // Abort at the second sample
        nfr++;
        start = 1'b1;
        bus.sample_valid = 1'b1;
        bus.res_ready = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("ab_busy", 64'(busy), 64'(0));
        chk("ab_rv", 64'(bus.res_valid), 64'(0));
        chk("ab_clr", 64'(bus.core_clr), 64'(0));
        chk("ab_rdy", 64'(bus.sample_ready), 64'(0));
        bus.sample_valid = 1'b0;
        tick;
        chk("ab_clr2", 64'(bus.core_clr), 64'(0));
        nfr++;
        do_frame(nfr);

        // Reset mid-RUN at the third sample
        start = 1'b1;
        bus.sample_valid = 1'b1;
        bus.res_ready = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        #1;
        chk("mr_outs", 64'({bus.sample_ready, bus.core_en, bus.core_clr, bus.res_valid, busy, overrun}), 64'(0));
        chk("mr_y1", 64'(bus.res_y1), 64'(0));
        chk("mr_y2", 64'(bus.res_y2), 64'(0));
        tick;
        rst = 1'b1;
        bus.sample_valid = 1'b0;
        tick;
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_rdy", 64'(bus.sample_ready), 64'(0));
        nfr = 1;
        do_frame(nfr);
`endif

        tick;
        chk("sb_empty", 64'(sbq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
